discrete_range_table_loader: RTL

// - Write side of the discrete range table: accepts per-variable lists of (start,end) ranges over a valid/ready stream and stores them.
// - Serves the registered read port used by the discrete range randomizer (variable index + range index -> start/end/size).
// - Sits between the host/constraint loader and the randomizer. The randomizer draws a random range index in [0,size-1] and reads that entry.

---
 rtl/discrete_range_table_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/discrete_range_table_loader.sv
// Write side of the discrete range table: streams per-variable (start,end) lists into
// a table and serves a registered read port for the discrete range randomizer.
module discrete_range_table_loader #(
  parameter  int NUM_VARIABLES                 = 16,
  parameter  int MAX_RANGES_PER_VAR            = 8,
  parameter  int BIT_WIDTH_OF_INTEGER_VARIABLE = 16,
  localparam int IW = $clog2(NUM_VARIABLES),
  localparam int RW = $clog2(MAX_RANGES_PER_VAR),
  localparam int SW = $clog2(MAX_RANGES_PER_VAR + 1),
  localparam int W  = BIT_WIDTH_OF_INTEGER_VARIABLE
) (
  input  logic          in_clock,
  input  logic          in_reset,
  input  logic          in_valid,
  output logic          out_ready,
  input  logic [IW-1:0] in_variable_index,
  input  logic [W-1:0]  in_start,
  input  logic [W-1:0]  in_end,
  input  logic          in_last,
  input  logic          in_clear_all,
  input  logic          in_clear_error,
  output logic          out_error_range,
  output logic          out_error_overflow,
  output logic          out_busy,
  input  logic [IW-1:0] in_read_variable_index,
  input  logic [RW-1:0] in_read_range_index,
  output logic [W-1:0]  out_read_start,
  output logic [W-1:0]  out_read_end,
  output logic [SW-1:0] out_read_size,
  output logic          out_read_hit,
  output logic          out_read_equal
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cur_var_q;
  logic [IW-1:0] clr_cnt_q;
  logic [SW-1:0] size_q [NUM_VARIABLES];
  logic [2*W-1:0] table_mem [NUM_VARIABLES][MAX_RANGES_PER_VAR];
  logic          err_range_q, err_overflow_q;
  logic [2*W-1:0] rd_data_q;
  logic          rd_hit_q;
  logic [SW-1:0] rd_size_q;

  logic          accept;
  logic [IW-1:0] wr_var;
  logic [SW-1:0] wr_n;
  logic          bad_range, full, do_store, clr_done, rd_hit_d;

  // The first beat of a list always starts the variable from an empty list.
  assign accept    = in_valid & out_ready;
  assign wr_var    = (state_q == S_IDLE) ? in_variable_index : cur_var_q;
  assign wr_n      = (state_q == S_IDLE) ? '0 : size_q[cur_var_q];
  assign bad_range = $signed(in_start) > $signed(in_end);
  assign full      = (wr_n == SW'(MAX_RANGES_PER_VAR));
  assign do_store  = accept & ~bad_range & ~full;
  assign clr_done  = (clr_cnt_q == IW'(NUM_VARIABLES - 1));

  always_ff @(posedge in_clock) begin
    if (in_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_clear_all) begin
          state_d = S_CLEAR;
        end else begin
          out_ready = 1'b1;
          if (in_valid && !in_last) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        out_ready = 1'b1;
        if (in_valid && in_last) state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (clr_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A variable under load or any variable during a clear is hidden from the reader.
  assign rd_hit_d = (SW'(in_read_range_index) < size_q[in_read_variable_index]) &&
                    (state_q != S_CLEAR) &&
                    !((state_q == S_LOAD) && (in_read_variable_index == cur_var_q));

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      cur_var_q      <= '0;
      clr_cnt_q      <= '0;
      err_range_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      rd_hit_q       <= 1'b0;
      rd_size_q      <= '0;
      for (int i = 0; i < NUM_VARIABLES; i++) size_q[i] <= '0;
    end else begin
      if (accept && state_q == S_IDLE) cur_var_q <= in_variable_index;
      clr_cnt_q <= (state_q == S_CLEAR) ? clr_cnt_q + IW'(1) : '0;
      if (state_q == S_CLEAR) size_q[clr_cnt_q] <= '0;
      if (accept) size_q[wr_var] <= do_store ? wr_n + SW'(1) : wr_n;
      err_range_q    <= (err_range_q & ~in_clear_error) | (accept & bad_range);
      err_overflow_q <= (err_overflow_q & ~in_clear_error) | (accept & ~bad_range & full);
      rd_hit_q       <= rd_hit_d;
      rd_size_q      <= size_q[in_read_variable_index];
    end
  end

  // Table storage: no reset, read-before-write on a shared address.
  always_ff @(posedge in_clock) begin
    if (do_store) table_mem[wr_var][wr_n[RW-1:0]] <= {in_start, in_end};
    rd_data_q <= table_mem[in_read_variable_index][in_read_range_index];
  end

  assign out_read_start     = rd_hit_q ? rd_data_q[2*W-1:W] : '0;
  assign out_read_end       = rd_hit_q ? rd_data_q[W-1:0]   : '0;
  assign out_read_equal     = rd_hit_q && (rd_data_q[2*W-1:W] == rd_data_q[W-1:0]);
  assign out_read_size      = rd_size_q;
  assign out_read_hit       = rd_hit_q;
  assign out_error_range    = err_range_q;
  assign out_error_overflow = err_overflow_q;
  assign out_busy           = (state_q != S_IDLE);

endmodule
